inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, instruction address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 2, fetch buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pc_i  input  ADDR_W  fetch address from the PC register.
REQ-007 SHALL have port ce_i  input  1  PC register chip enable; no fetch issued while 0.
REQ-008 SHALL have port pc_ready_o  output  1  pulse: pc_i accepted, PC may advance.
REQ-009 SHALL have port flush_i  input  1  redirect: discard all buffered and in-flight fetches.
REQ-010 SHALL have port mem_req_o  output  1  instruction memory request valid.
REQ-011 SHALL have port mem_addr_o  output  ADDR_W  request address.
REQ-012 SHALL have port mem_gnt_i  input  1  memory accepts request this cycle.
REQ-013 SHALL have port mem_rvalid_i  input  1  read data valid.
REQ-014 SHALL have port mem_rdata_i  input  INST_W  read data.
REQ-015 SHALL have port if_valid_o  output  1  buffer head valid toward decode.
REQ-016 SHALL have port if_pc_o  output  ADDR_W  PC of head entry.
REQ-017 SHALL have port if_inst_o  output  INST_W  instruction of head entry.
REQ-018 SHALL have port id_ready_i  input  1  decode consumes head when if_valid_o=1.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, WAIT; at most one memory request outstanding.
REQ-020 SHALL, in IDLE, move to REQ when ce_i=1, flush_i=0 and (count + outstanding) < DEPTH.
REQ-021 SHALL, in REQ, drive mem_req_o=1, mem_addr_o={pc_i[ADDR_W-1:2],2'b00}, latch pc_i as tag; mem_req_o and mem_addr_o held stable until mem_gnt_i=1.
REQ-022 SHALL, on mem_req_o & mem_gnt_i, assert pc_ready_o for exactly that cycle and move to WAIT; pc_ready_o=0 otherwise.
REQ-023 SHALL, in WAIT on mem_rvalid_i=1, push {tag, mem_rdata_i} into the buffer and go to REQ if request conditions of REQ-020 still hold (counting the push), else IDLE.
REQ-024 SHALL present the pushed entry on if_valid_o/if_pc_o/if_inst_o the cycle after mem_rvalid_i (one-cycle latency) when the buffer was empty.
REQ-025 SHALL pop the head on if_valid_o & id_ready_i; push and pop in the same cycle leave count unchanged.
REQ-026 SHALL never push when full; reservation via outstanding counter guarantees space for every accepted request.
REQ-027 SHALL keep buffer order FIFO; pointers wrap modulo DEPTH.
REQ-028 SHALL, on flush_i=1: empty buffer next cycle (if_valid_o=0), drop mem_req_o if not yet granted, return to IDLE.
REQ-029 SHALL, on flush_i=1 while WAIT or coincident with a grant, set a drop flag; the next mem_rvalid_i is discarded (no push), flag cleared, FSM to IDLE.
REQ-030 SHALL, on flush_i coincident with mem_rvalid_i, discard that data.
REQ-031 SHALL ignore mem_rvalid_i when no request outstanding.
REQ-032 SHALL ignore ce_i falling while WAIT; the outstanding response completes normally.

Reset
REQ-033 SHALL, on rst=1 (asynchronous), force FSM=IDLE, count=0, pointers=0, drop flag=0, outstanding=0, mem_req_o=0, mem_addr_o=0, pc_ready_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
REQ-034 SHALL discard any in-flight memory response after reset deassertion until a new request is granted.

Verification
REQ-035 Basic: rst released, ce_i=1, pc_i=0x0, gnt immediate, rvalid next cycle with 0x00000013, id_ready_i=1 -> if_valid_o=1, if_pc_o=0x0, if_inst_o=0x00000013 one cycle after rvalid; pc_ready_o one pulse.
REQ-036 Backpressure: id_ready_i=0, pcs 0x0,0x4,0x8 offered -> exactly DEPTH=2 grants, mem_req_o stays 0, pc_ready_o absent for 0x8 until a pop.
REQ-037 Grant stall: mem_gnt_i=0 for 3 cycles at pc_i=0x10 -> mem_req_o=1, mem_addr_o=0x10 stable all 3 cycles, pc_ready_o only on grant cycle.
REQ-038 Flush in flight: grant 0x20, flush_i in WAIT, rvalid with 0xDEADBEEF -> no push, if_valid_o=0, next fetch from new pc_i=0x100 delivered with if_pc_o=0x100.
REQ-039 Async reset: rst pulsed mid-cycle with 2 buffered entries -> if_valid_o=0 and mem_req_o=0 immediately, before next clk edge.

Source files
------------

// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch: single-outstanding instruction fetch unit with a FIFO fetch buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  input  logic              id_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] tag;
  logic              outstanding;
  logic              drop;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              grant;
  logic              resp;
  logic              push;
  logic              pop;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  assign grant       = (state == REQ) && mem_gnt_i;
  assign resp        = mem_rvalid_i && outstanding;
  assign push        = resp && (state == WAIT) && !drop && !flush_i;
  assign pop         = (count != '0) && id_ready_i && !flush_i;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  // A new fetch waits for any dropped response still in flight, which keeps
  // the memory interface at one outstanding request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ce_i && !flush_i && !outstanding && (count < FULL)) state_nxt = REQ;
      end
      REQ: begin
        if (flush_i)        state_nxt = IDLE;
        else if (mem_gnt_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (flush_i)           state_nxt = IDLE;
        else if (mem_rvalid_i) state_nxt = (ce_i && (count_after < FULL)) ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tag         <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == REQ) && (state != REQ)) tag <= pc_i;

      if (grant)             outstanding <= 1'b1;
      else if (mem_rvalid_i) outstanding <= 1'b0;

      // A response already granted but redirected away must be swallowed.
      if (flush_i && (grant || ((state == WAIT) && !mem_rvalid_i))) drop <= 1'b1;
      else if (resp)                                               drop <= 1'b0;

      if (flush_i) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count_after;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= tag;
      inst_mem[wr_ptr] <= mem_rdata_i;
    end
  end

  assign mem_req_o  = (state == REQ);
  assign mem_addr_o = {tag[ADDR_W-1:2], 2'b00};
  assign pc_ready_o = grant;
  assign if_valid_o = (count != '0);
  assign if_pc_o    = if_valid_o ? pc_mem[rd_ptr]   : '0;
  assign if_inst_o  = if_valid_o ? inst_mem[rd_ptr] : '0;

endmodule

`default_nettype wire
